fir_data_loader: RTL and testbench
==================================

FIR_DATA_LOADER -- requirements
Module: fir_data_loader

Parameters
REQ-001 The block SHALL have parameter INPUT_BASE, default 32'd0, the byte address of the first input sample word.
REQ-002 The block SHALL have parameter COEFF_BASE, default 32'd64, the byte address of the first coefficient word.
REQ-003 The block SHALL have parameter OUTPUT_BASE, default 32'd128, the byte address of the first output word to be cleared.
REQ-004 The block SHALL have parameter NUM_TAPS, default 4, the number of coefficient words accepted (minimum 1).
REQ-005 The block SHALL have parameter NUM_SAMPLES, default 5, the number of sample words accepted and output words cleared (minimum 1).

Interface
REQ-006 The block SHALL have port clock, input, 1 bit, the sole clock, with all logic on the rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, a single-cycle load request.
REQ-009 The block SHALL have port in_valid, input, 1 bit, which is high when in_data holds a word.
REQ-010 The block SHALL have port in_ready, output, 1 bit, which is high when the block accepts a word.
REQ-011 The block SHALL have port in_data, input, 32 bits, carrying a coefficient word or a sample word.
REQ-012 The block SHALL have port mem_we, output, 1 bit, the data memory write strobe.
REQ-013 The block SHALL have port mem_addr, output, 32 bits, the byte address of the write.
REQ-014 The block SHALL have port mem_wdata, output, 32 bits, the write data.
REQ-015 The block SHALL have port busy, output, 1 bit, which is high in every state except IDLE and DONE.
REQ-016 The block SHALL have port load_done, output, 1 bit, a level signal that tells the downstream FIR controller that memory is ready.

Function
REQ-017 The block SHALL implement the states IDLE, CLEAR_OUT, LOAD_COEFF, LOAD_INPUT, FLUSH and DONE, together with one word counter cnt.
REQ-018 IDLE or DONE SHALL go to CLEAR_OUT when start=1, with cnt=0 and load_done cleared; start SHALL be ignored in all other states.
REQ-019 CLEAR_OUT SHALL issue one write per cycle of data 0 to address OUTPUT_BASE+4*cnt.
REQ-020 CLEAR_OUT SHALL move to LOAD_COEFF with cnt reset to 0 after cnt = NUM_SAMPLES-1.
REQ-021 in_ready SHALL be a decode of the state register only: 1 in LOAD_COEFF and LOAD_INPUT, and 0 in all other states.
REQ-022 A transfer SHALL occur when in_valid=1 and in_ready=1 in the same cycle; with in_valid=0 the state and cnt SHALL hold.
REQ-023 A transfer in LOAD_COEFF SHALL write in_data to COEFF_BASE+4*cnt.
REQ-024 A transfer in LOAD_COEFF at cnt = NUM_TAPS-1 SHALL move to LOAD_INPUT with cnt=0, and in_ready SHALL stay high across that boundary.
REQ-025 A transfer in LOAD_INPUT SHALL write in_data to INPUT_BASE+4*cnt.
REQ-026 A transfer in LOAD_INPUT at cnt = NUM_SAMPLES-1 SHALL move to FLUSH.
REQ-027 FLUSH SHALL last one cycle and then go to DONE; load_done SHALL be 1 in DONE and 0 in all other states.
REQ-028 mem_we, mem_addr and mem_wdata SHALL be registered, appearing one cycle after the clear cycle or transfer cycle that produces them.
REQ-029 The block SHALL issue at most one write per cycle and writes SHALL never overlap.
REQ-030 The last clear write SHALL appear during the first LOAD_COEFF cycle.
REQ-031 The last sample write SHALL appear during FLUSH, so load_done rises exactly one cycle after the final mem_we.
REQ-032 mem_addr and mem_wdata SHALL hold their last values while mem_we=0.
REQ-033 Address arithmetic SHALL be 32-bit unsigned modulo 2^32, and cnt SHALL be 32 bits wide.
REQ-034 In IDLE and DONE, in_valid SHALL be ignored and no writes SHALL be issued.

Reset
REQ-035 While reset=1 the block SHALL go to IDLE with cnt=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0 and load_done=0.
REQ-036 Reset SHALL take priority over start and transfers, and a reset during an operation SHALL abort it with no write on the following cycle.
REQ-037 Memory contents already written before a reset SHALL be left as they are.

Verification
REQ-038 Scenario, full load with defaults and in_valid held high: pulse start. Required: clear writes of 0 to 128, 132, 136, 140, 144; coefficient writes to 64..76; sample writes to 0..16; load_done high one cycle after the write to 16; total of 14 writes.
REQ-039 Scenario, back-pressure: toggle in_valid every other cycle during LOAD_COEFF. Required: cnt advances only on transfers, the addresses have no gaps, and no duplicate writes occur.
REQ-040 Scenario, start while busy: pulse start during LOAD_INPUT at cnt=2. Required: no restart and no change to the write sequence.
REQ-041 Scenario, reset mid-load: assert reset during LOAD_COEFF at cnt=1. Required: next cycle mem_we=0, in_ready=0 and busy=0; a later start re-runs from CLEAR_OUT with address 128.
REQ-042 Scenario, reload from DONE: pulse start while load_done=1. Required: load_done falls the next cycle and the full sequence repeats identically.
REQ-043 Scenario, NUM_TAPS=1 and NUM_SAMPLES=1: run a full load. Required: one clear write, one coefficient write and one sample write, and the LOAD_COEFF to LOAD_INPUT transition after a single transfer.

Source files
------------

// File: rtl/fir_data_loader.sv
// fir_data_loader: clears the FIR output buffer, then streams coefficient and
// sample words from a valid/ready input into data memory, and finally raises
// load_done so the downstream FIR controller can start.
module fir_data_loader #(
    parameter logic [31:0] INPUT_BASE  = 32'd0,
    parameter logic [31:0] COEFF_BASE  = 32'd64,
    parameter logic [31:0] OUTPUT_BASE = 32'd128,
    parameter int          NUM_TAPS    = 4,
    parameter int          NUM_SAMPLES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        load_done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_OUT,
        LOAD_COEFF,
        LOAD_INPUT,
        FLUSH,
        DONE
    } state_t;

    localparam logic [31:0] LAST_TAP    = 32'(NUM_TAPS - 1);
    localparam logic [31:0] LAST_SAMPLE = 32'(NUM_SAMPLES - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] cnt;
    logic [31:0] next_cnt;
    logic        next_we;
    logic [31:0] next_addr;
    logic [31:0] next_wdata;

    // Handshake and status flags decode straight from the state register so
    // in_ready never depends on in_valid in the same cycle.
    assign in_ready  = (state == LOAD_COEFF) || (state == LOAD_INPUT);
    assign busy      = (state != IDLE) && (state != DONE);
    assign load_done = (state == DONE);

    // State, word counter and the registered memory write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            mem_we    <= next_we;
            mem_addr  <= next_addr;
            mem_wdata <= next_wdata;
        end
    end

    // Next-state logic; address and data hold their last value unless a
    // clear cycle or an accepted transfer produces a new write.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_we    = 1'b0;
        next_addr  = mem_addr;
        next_wdata = mem_wdata;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = CLEAR_OUT;
                    next_cnt   = 32'd0;
                end
            end
            CLEAR_OUT: begin
                next_we    = 1'b1;
                next_addr  = OUTPUT_BASE + (cnt << 2);
                next_wdata = 32'd0;
                if (cnt == LAST_SAMPLE) begin
                    next_state = LOAD_COEFF;
                    next_cnt   = 32'd0;
                end else begin
                    next_cnt = cnt + 32'd1;
                end
            end
            LOAD_COEFF: begin
                if (in_valid) begin
                    next_we    = 1'b1;
                    next_addr  = COEFF_BASE + (cnt << 2);
                    next_wdata = in_data;
                    if (cnt == LAST_TAP) begin
                        next_state = LOAD_INPUT;
                        next_cnt   = 32'd0;
                    end else begin
                        next_cnt = cnt + 32'd1;
                    end
                end
            end
            LOAD_INPUT: begin
                if (in_valid) begin
                    next_we    = 1'b1;
                    next_addr  = INPUT_BASE + (cnt << 2);
                    next_wdata = in_data;
                    if (cnt == LAST_SAMPLE) begin
                        next_state = FLUSH;
                        next_cnt   = 32'd0;
                    end else begin
                        next_cnt = cnt + 32'd1;
                    end
                end
            end
            FLUSH: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_data_loader.sv
// tb_fir_data_loader: randomized bench comparing two loader instances
// (default sizes and a 1-tap/1-sample build) against a sequence-level model.
module tb_fir_data_loader;

    typedef struct {
        bit          active;
        bit          flush;
        bit          done;
        int          pos;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } model_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;

    logic        in_ready_a, mem_we_a, busy_a, load_done_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic        in_ready_b, mem_we_b, busy_b, load_done_b;
    logic [31:0] mem_addr_b, mem_wdata_b;

    model_t ma = '{default: 0};
    model_t mb = '{default: 0};
    int     errorCount = 0;
    int     checkCount = 0;
    int     writesA = 0;
    int     writesB = 0;

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    fir_data_loader dutA (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .busy(busy_a),
        .load_done(load_done_a)
    );

    fir_data_loader #(.NUM_TAPS(1), .NUM_SAMPLES(1)) dutB (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .busy(busy_b),
        .load_done(load_done_b)
    );

    // One clock of the load sequence: ns clear slots, then nt+ns accepted
    // words, then a single flush cycle, then done.
    function automatic model_t stepModel(model_t m, bit rst, bit st, bit vld,
                                         logic [31:0] d, int nt, int ns);
        model_t r = m;
        int     k;
        r.we = 1'b0;
        if (rst) begin
            r = '{default: 0};
        end else if (m.flush) begin
            r.flush = 1'b0;
            r.done  = 1'b1;
        end else if (!m.active) begin
            if (st) begin
                r.active = 1'b1;
                r.pos    = 0;
                r.done   = 1'b0;
            end
        end else if (m.pos < ns) begin
            r.we    = 1'b1;
            r.addr  = 32'd128 + 32'(4 * m.pos);
            r.wdata = 32'd0;
            r.pos   = m.pos + 1;
        end else if (vld) begin
            k       = m.pos - ns;
            r.we    = 1'b1;
            r.addr  = (k < nt) ? 32'd64 + 32'(4 * k) : 32'd0 + 32'(4 * (k - nt));
            r.wdata = d;
            r.pos   = m.pos + 1;
            if (r.pos == ns + nt + ns) begin
                r.active = 1'b0;
                r.flush  = 1'b1;
            end
        end
        return r;
    endfunction

    // Advance both reference models on the same edge the DUTs see.
    always @(posedge clock) begin
        ma <= stepModel(ma, reset, start, in_valid, in_data, 4, 5);
        mb <= stepModel(mb, reset, start, in_valid, in_data, 1, 1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every output of both instances once per cycle, mid-period.
    always @(negedge clock) begin
        checkOutput("A in_ready", in_ready_a, ma.active && ma.pos >= 5);
        checkOutput("A busy", busy_a, ma.active || ma.flush);
        checkOutput("A load_done", load_done_a, ma.done);
        checkOutput("A mem_we", mem_we_a, ma.we);
        checkOutput("A mem_addr", mem_addr_a, ma.addr);
        checkOutput("A mem_wdata", mem_wdata_a, ma.wdata);
        checkOutput("B in_ready", in_ready_b, mb.active && mb.pos >= 1);
        checkOutput("B busy", busy_b, mb.active || mb.flush);
        checkOutput("B load_done", load_done_b, mb.done);
        checkOutput("B mem_we", mem_we_b, mb.we);
        checkOutput("B mem_addr", mem_addr_b, mb.addr);
        checkOutput("B mem_wdata", mem_wdata_b, mb.wdata);
        if (mem_we_a) writesA <= writesA + 1;
        if (mem_we_b) writesB <= writesB + 1;
    end

    task automatic applyStimulus(input bit st, input bit vld);
        start    = st;
        in_valid = vld;
        in_data  = $urandom;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid toggles, 2: random valid,
    // 3: valid high plus a start pulse in LOAD_INPUT at cnt=2.
    task automatic runToDone(input int mode, input string tag);
        for (int i = 0; i < 300 && !ma.done; i++) begin
            case (mode)
                1:       applyStimulus(1'b0, i[0]);
                2:       applyStimulus(1'b0, 1'($urandom_range(0, 1)));
                3:       applyStimulus(ma.active && ma.pos == 11, 1'b1);
                default: applyStimulus(1'b0, 1'b1);
            endcase
        end
        checkOutput({tag, " reached done"}, 32'(ma.done), 32'd1);
    endtask

    int baseA;
    int baseB;

    initial begin
        #1;
        repeat (3) applyStimulus(1'b0, 1'b0);
        reset = 1'b0;

        baseA = writesA;
        baseB = writesB;
        applyStimulus(1'b1, 1'b1);
        runToDone(0, "full load");
        checkOutput("full load writes A", 32'(writesA - baseA), 32'd14);
        checkOutput("full load writes B", 32'(writesB - baseB), 32'd3);
        applyStimulus(1'b0, 1'b1);

        baseA = writesA;
        applyStimulus(1'b1, 1'b0);
        runToDone(1, "backpressure");
        checkOutput("backpressure writes A", 32'(writesA - baseA), 32'd14);

        baseA = writesA;
        applyStimulus(1'b1, 1'b1);
        runToDone(3, "start while busy");
        checkOutput("start while busy writes A", 32'(writesA - baseA), 32'd14);

        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 50 && !(ma.active && ma.pos == 6); i++)
            applyStimulus(1'b0, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1);
        reset = 1'b0;
        checkOutput("reset mem_we", 32'(mem_we_a), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready_a), 32'd0);
        checkOutput("reset busy", 32'(busy_a), 32'd0);
        applyStimulus(1'b0, 1'b1);
        baseA = writesA;
        applyStimulus(1'b1, 1'b1);
        runToDone(0, "rerun after reset");
        checkOutput("rerun writes A", 32'(writesA - baseA), 32'd14);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            baseA = writesA;
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            runToDone(2, "random valid");
            checkOutput("random valid writes A", 32'(writesA - baseA), 32'd14);
        end

        repeat (3) applyStimulus(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
